jtframe_dip_sync: RTL and testbench
===================================

# jtframe_dip_sync

Frame-aligned OSD status decoder; parametrised successor of the framework's DIP/status decoder. Synchronises and debounces the OSD `status` word. Commits changes only at the start of vertical blank, so video and sound settings never change mid-frame. Adds a pause FSM with single-frame step. Sits between the OSD/ARM status bus and the game core, replacing direct combinational decoding.

## Interface
Parameters:
- `SW`, 32: status word width.
- `NB`, 2: number of core DIP banks exported.
- `DW`, 8: bits per DIP bank.
- `BASE`, 16: status bit of bank 0 LSB. Bank k occupies `status[BASE+k*DW +: DW]`. Requires `BASE+NB*DW <= SW`.
- `STABLE`, 1024: cycles a synchronised value must hold before it is commit-eligible. Minimum 2.
- `VERT`, 0: 1 enables vertical-game rotation logic.

Ports:
- `clk  in  1  system clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `status  in  SW  OSD status word, asynchronous to clk`
- `core_mod  in  7  bit0=1: vertical game`
- `game_pause  in  1  active-high pause request from core`
- `vblank  in  1  vertical blank, clk domain`
- `step  in  1  one-cycle pulse: advance one frame while paused`
- `dip_bank  out  NB*DW  committed core DIP banks`
- `dip_upd  out  1  one-cycle pulse on every commit`
- `dip_pause  out  1  active low: 0 halts the core CPU`
- `rotate  out  2  {flip, tate}`
- `hdmi_arx, hdmi_ary  out  8 each  aspect ratio`
- `scanlines  out  3  status[5:3] committed`
- `dip_fxlevel  out  2  2'b10 ^ status[7:6] committed`
- `enable_psg, enable_fm  out  1 each  ~status[8], ~status[9] committed`
- `dip_test  out  1  ~status[10] committed`

## Operation
- Sync: two flops on `status`, giving `s2`.
- Debounce:
  - If `s2 != cand`: `cand<=s2`, `cnt<=0`.
  - Otherwise `cnt` increments and saturates at `STABLE-1`.
  - `stable = (cnt==STABLE-1)`.
- Commit:
  - `vb_rise = vblank & ~vblank_q`.
  - On `vb_rise & stable & (cand != com)`: `com<=cand`, `dip_upd<=1` for one cycle.
  - No commit occurs outside `vb_rise`.
- Derived outputs come from `com` and are registered:
  - `tate = VERT & core_mod[0] & ~com[2]`.
  - `flip = com[1]`.
  - `com[11]` (widescreen) gives 16:9. Otherwise `tate` gives 3:4, and `~tate` gives 4:3.
- Pause request: `req = com[15] | game_pause`.
- Pause FSM states:
  - RUN: `req` → PEND.
  - PEND: `~req` → RUN. `vb_rise` → PAUSED.
  - PAUSED: `~req` → RUN on the next `vb_rise`. `step` → STEP. If `~req` and `step` occur together, `~req` wins.
  - STEP: `vb_rise` → PAUSED, or → RUN if `~req`. `step` pulses received in STEP are ignored.
- `dip_pause = 0` only in PAUSED. RUN, PEND and STEP drive 1.

## Timing
- Reset values:
  - `s2`, `cand`, `com` = 0; `cnt` = 0.
  - FSM in RUN.
  - `dip_pause=1`, `dip_upd=0`, `dip_bank=0`, `scanlines=0`.
  - `dip_fxlevel=2'b10`, `enable_psg=enable_fm=1`, `dip_test=1`, `rotate={0,VERT&core_mod[0]}`.
  - `hdmi_arx/ary` = 4/3, or 3/4 when tate.
- Latency from a `status` change to eligibility: 2 sync cycles plus `STABLE` cycles. The commit then happens at the first `vb_rise` after that.
- `dip_upd` asserts the cycle after the `vb_rise` sample. Derived outputs update one cycle after `dip_upd`.
- If `status` changes in the same cycle as `vb_rise`, the already-stable `cand` still commits. The new value restarts debounce.
- A change shorter than `STABLE` cycles is never committed.
- The FSM updates one cycle after its input. `dip_pause` changes exactly one cycle after the `vb_rise` that causes the transition.
- `rst_n` low at any time immediately clears all state, including mid-debounce and mid-STEP. Release is synchronous to `clk`, via the framework's reset synchroniser upstream.

## Structure
- `jtframe_dip_pkg`:
  - Status bit indices: FLIP=1, ROT=2, SCAN=3..5, FX=6..7, PSG=8, FM=9, TEST=10, WIDE=11, PAUSE=15.
  - Pause FSM state enum {RUN, PEND, PAUSED, STEP}.
- Sub-module `jtframe_dip_filter`, parametrised by `SW` and `STABLE`. It contains the sync flops and the debounce counter, and outputs `cand` and `stable`.
- Top level holds the vblank edge detector, commit register, decode and pause FSM.

## Test plan
Bench uses `STABLE=4`, `NB=2`, `DW=8`, `BASE=16`.
- Reset with `status=0`, `VERT=1`, `core_mod=1` → `dip_pause=1`, `rotate=2'b01`, `hdmi_arx/ary=3/4`, `dip_fxlevel=2'b10`, `dip_bank=0`.
- Set `status[23:16]=8'hA5` and hold 10 cycles, then `vb_rise` → one `dip_upd` pulse, `dip_bank[7:0]=8'hA5`. No change is visible before `vb_rise`.
- Toggle `status[9]` for 2 cycles only, then `vb_rise` → no `dip_upd`, `enable_fm` stays 1.
- `game_pause=1` mid-frame → `dip_pause` stays 1 until the next `vb_rise`, then goes 0. `game_pause=0` → returns to 1 at the following `vb_rise`.
- While PAUSED, pulse `step` → `dip_pause=1` for exactly one frame, then 0 again. A second `step` during STEP is ignored.
- Assert `rst_n=0` while in STEP with a pending `cand` → all outputs return to reset values immediately. After release, no commit occurs until `STABLE` cycles and a `vb_rise` have passed.

Source files
------------

// File: rtl/jtframe_dip_pkg.sv
// Shared definitions for the frame-aligned OSD status decoder.
// - Bit positions of the framework-owned fields in the OSD status word.
// - Pause FSM state encoding.
// - Aspect-ratio helper used by the decode stage.
package jtframe_dip_pkg;

  localparam int BIT_FLIP  = 1;
  localparam int BIT_ROT   = 2;
  localparam int BIT_SCAN  = 3;   // 3-bit field, bits 5:3
  localparam int BIT_FX    = 6;   // 2-bit field, bits 7:6
  localparam int BIT_PSG   = 8;
  localparam int BIT_FM    = 9;
  localparam int BIT_TEST  = 10;
  localparam int BIT_WIDE  = 11;
  localparam int BIT_PAUSE = 15;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } pause_st_e;

  // Returns {arx, ary}. Widescreen overrides rotation.
  function automatic logic [15:0] aspect(input logic wide, input logic tate);
    if (wide)      aspect = {8'd16, 8'd9};
    else if (tate) aspect = {8'd3,  8'd4};
    else           aspect = {8'd4,  8'd3};
  endfunction

endpackage

// File: rtl/jtframe_dip_filter.sv
// Synchroniser and debouncer for the OSD status word.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   status     : OSD status word, asynchronous to clk
//   cand       : last synchronised value seen (commit candidate)
//   stable     : cand has held for STABLE consecutive cycles
module jtframe_dip_filter #(
  parameter int SW     = 32,
  parameter int STABLE = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] status,
  output logic [SW-1:0] cand,
  output logic          stable
);

  localparam int             CW   = $clog2(STABLE);
  localparam logic [CW-1:0]  CMAX = CW'(STABLE - 1);

  logic [SW-1:0] sync_p0;
  logic [SW-1:0] sync_p1;
  logic [CW-1:0] cnt;

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= status;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: candidate capture and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync_p1 != cand) begin
      cand <= sync_p1;
      cnt  <= '0;
    end else if (cnt != CMAX) begin
      cnt  <= cnt + CW'(1);
    end
  end

  assign stable = (cnt == CMAX);

endmodule

// File: rtl/jtframe_dip_sync.sv
// Frame-aligned OSD status decoder.
// Debounced status changes are committed only on the rising edge of vblank,
// then decoded into registered core settings. Includes a pause FSM with
// single-frame stepping.
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   status             : OSD status word (asynchronous)
//   core_mod           : bit0 = vertical game
//   game_pause         : pause request from the core
//   vblank             : vertical blank (clk domain)
//   step               : one-cycle pulse, advance one frame while paused
//   dip_bank           : committed core DIP banks
//   dip_upd            : one-cycle pulse per commit
//   dip_pause          : active low, 0 halts the core CPU
//   rotate             : {flip, tate}
//   hdmi_arx/hdmi_ary  : aspect ratio
//   scanlines, dip_fxlevel, enable_psg, enable_fm, dip_test : decoded settings
module jtframe_dip_sync
  import jtframe_dip_pkg::*;
#(
  parameter int SW     = 32,
  parameter int NB     = 2,
  parameter int DW     = 8,
  parameter int BASE   = 16,
  parameter int STABLE = 1024,
  parameter int VERT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SW-1:0]      status,
  input  logic [6:0]         core_mod,
  input  logic               game_pause,
  input  logic               vblank,
  input  logic               step,
  output logic [NB*DW-1:0]   dip_bank,
  output logic               dip_upd,
  output logic               dip_pause,
  output logic [1:0]         rotate,
  output logic [7:0]         hdmi_arx,
  output logic [7:0]         hdmi_ary,
  output logic [2:0]         scanlines,
  output logic [1:0]         dip_fxlevel,
  output logic               enable_psg,
  output logic               enable_fm,
  output logic               dip_test
);

  localparam logic VERT_EN = (VERT != 0);

  logic [SW-1:0] cand;
  logic          stable;
  logic [SW-1:0] com;
  logic          vblank_q;
  logic          vb_rise;
  logic          flip_q;
  logic          rot_q;
  logic          wide_q;
  logic          tate;
  logic          req;
  pause_st_e     st;
  pause_st_e     st_nx;

  jtframe_dip_filter #(
    .SW     (SW),
    .STABLE (STABLE)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .status (status),
    .cand   (cand),
    .stable (stable)
  );

  assign vb_rise = vblank & ~vblank_q;

  // Commit stage: only a candidate that is already stable at the vblank
  // edge is taken, so a change arriving on that same edge waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
      com      <= '0;
      dip_upd  <= 1'b0;
    end else begin
      vblank_q <= vblank;
      dip_upd  <= 1'b0;
      if (vb_rise && stable && (cand != com)) begin
        com     <= cand;
        dip_upd <= 1'b1;
      end
    end
  end

  // Decode stage: settings follow com one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dip_bank    <= '0;
      scanlines   <= 3'd0;
      dip_fxlevel <= 2'b10;
      enable_psg  <= 1'b1;
      enable_fm   <= 1'b1;
      dip_test    <= 1'b1;
      flip_q      <= 1'b0;
      rot_q       <= 1'b0;
      wide_q      <= 1'b0;
    end else begin
      dip_bank    <= com[BASE +: NB*DW];
      scanlines   <= com[BIT_SCAN +: 3];
      dip_fxlevel <= 2'b10 ^ com[BIT_FX +: 2];
      enable_psg  <= ~com[BIT_PSG];
      enable_fm   <= ~com[BIT_FM];
      dip_test    <= ~com[BIT_TEST];
      flip_q      <= com[BIT_FLIP];
      rot_q       <= com[BIT_ROT];
      wide_q      <= com[BIT_WIDE];
    end
  end

  // core_mod is a static core property, so tate is formed from the
  // registered rotation bit rather than registered itself; this also
  // gives the correct reset value without loading an input under reset.
  assign tate                 = VERT_EN & core_mod[0] & ~rot_q;
  assign rotate               = {flip_q, tate};
  assign {hdmi_arx, hdmi_ary} = aspect(wide_q, tate);

  assign req = com[BIT_PAUSE] | game_pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else        st <= st_nx;
  end

  // Releasing the pause always waits for the next frame boundary, and a
  // release request takes priority over a step request.
  always_comb begin
    st_nx     = st;
    dip_pause = (st != PAUSED);
    case (st)
      RUN:    if (req) st_nx = PEND;
      PEND:   if (!req) st_nx = RUN;
              else if (vb_rise) st_nx = PAUSED;
      PAUSED: if (!req) begin
                if (vb_rise) st_nx = RUN;
              end else if (step) begin
                st_nx = STEP;
              end
      STEP:   if (vb_rise) st_nx = req ? PAUSED : RUN;
      default: st_nx = RUN;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{core_mod[6:1], com};

endmodule

// File: tb/tb_jtframe_dip_sync.sv
module tb_jtframe_dip_sync;

  logic        clk;
  logic        rst_n;
  logic [31:0] status;
  logic [6:0]  core_mod;
  logic        game_pause;
  logic        vblank;
  logic        step;
  logic [15:0] dip_bank;
  logic        dip_upd;
  logic        dip_pause;
  logic [1:0]  rotate;
  logic [7:0]  hdmi_arx;
  logic [7:0]  hdmi_ary;
  logic [2:0]  scanlines;
  logic [1:0]  dip_fxlevel;
  logic        enable_psg;
  logic        enable_fm;
  logic        dip_test;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  jtframe_dip_sync #(
    .SW(32), .NB(2), .DW(8), .BASE(16), .STABLE(4), .VERT(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .status      (status),
    .core_mod    (core_mod),
    .game_pause  (game_pause),
    .vblank      (vblank),
    .step        (step),
    .dip_bank    (dip_bank),
    .dip_upd     (dip_upd),
    .dip_pause   (dip_pause),
    .rotate      (rotate),
    .hdmi_arx    (hdmi_arx),
    .hdmi_ary    (hdmi_ary),
    .scanlines   (scanlines),
    .dip_fxlevel (dip_fxlevel),
    .enable_psg  (enable_psg),
    .enable_fm   (enable_fm),
    .dip_test    (dip_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dip_upd === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vb();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pause"},  {31'd0, dip_pause},  32'd1);
    chk({tag, "_upd"},    {31'd0, dip_upd},    32'd0);
    chk({tag, "_bank"},   {16'd0, dip_bank},   32'd0);
    chk({tag, "_rotate"}, {30'd0, rotate},     32'd1);
    chk({tag, "_arx"},    {24'd0, hdmi_arx},   32'd3);
    chk({tag, "_ary"},    {24'd0, hdmi_ary},   32'd4);
    chk({tag, "_fx"},     {30'd0, dip_fxlevel}, 32'd2);
    chk({tag, "_scan"},   {29'd0, scanlines},  32'd0);
    chk({tag, "_psgfm"},  {30'd0, enable_psg, enable_fm}, 32'd3);
    chk({tag, "_test"},   {31'd0, dip_test},   32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    status     = 32'h0;
    core_mod   = 7'd1;
    game_pause = 1'b0;
    vblank     = 1'b0;
    step       = 1'b0;
    ticks(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    ticks(8);
    chk("idle_upd_cnt", upd_cnt, 0);

    // Bank 0 commit, gated by vblank
    status = 32'h00A5_0000;
    ticks(10);
    chk("a5_before_vb_bank", {16'd0, dip_bank}, 32'h0);
    chk("a5_before_vb_upd",  upd_cnt, 0);
    vb();
    chk("a5_upd_pulse", {31'd0, dip_upd}, 32'd1);
    chk("a5_bank_lag",  {16'd0, dip_bank}, 32'h0);
    tick();
    chk("a5_bank",      {16'd0, dip_bank}, 32'h00A5);
    chk("a5_upd_low",   {31'd0, dip_upd}, 32'd0);
    chk("a5_upd_cnt",   upd_cnt, 1);

    // Short glitch on the FM bit is never committed
    status = 32'h00A5_0200;
    ticks(2);
    status = 32'h00A5_0000;
    tick();
    vb();
    tick();
    chk("glitch_upd_cnt", upd_cnt, 1);
    chk("glitch_fm",      {31'd0, enable_fm}, 32'd1);
    ticks(10);
    vb();
    tick();
    chk("glitch_settled_upd_cnt", upd_cnt, 1);

    // Scanlines, FX, flip, widescreen
    status = 32'h00A5_08EA;
    ticks(10);
    chk("c1_scan_before_vb", {29'd0, scanlines}, 32'd0);
    vb();
    tick();
    chk("c1_upd_cnt", upd_cnt, 2);
    chk("c1_scan",    {29'd0, scanlines},   32'd5);
    chk("c1_fx",      {30'd0, dip_fxlevel}, 32'd1);
    chk("c1_rotate",  {30'd0, rotate},      32'd3);
    chk("c1_arx",     {24'd0, hdmi_arx},    32'd16);
    chk("c1_ary",     {24'd0, hdmi_ary},    32'd9);

    // Rotation disabled, PSG and test bits set, widescreen off
    status = 32'h00A5_05EE;
    ticks(10);
    vb();
    tick();
    chk("c2_upd_cnt", upd_cnt, 3);
    chk("c2_rotate",  {30'd0, rotate},   32'd2);
    chk("c2_arx",     {24'd0, hdmi_arx}, 32'd4);
    chk("c2_ary",     {24'd0, hdmi_ary}, 32'd3);
    chk("c2_psg",     {31'd0, enable_psg}, 32'd0);
    chk("c2_fm",      {31'd0, enable_fm},  32'd1);
    chk("c2_test",    {31'd0, dip_test},   32'd0);

    // Status changes on the same cycle as the vblank edge
    status = 32'h3CA5_05EE;
    ticks(10);
    status = 32'h5AA5_05EE;
    vb();
    tick();
    chk("same_cycle_bank",    {16'd0, dip_bank}, 32'h3CA5);
    chk("same_cycle_upd_cnt", upd_cnt, 4);
    ticks(10);
    vb();
    tick();
    chk("followup_bank",    {16'd0, dip_bank}, 32'h5AA5);
    chk("followup_upd_cnt", upd_cnt, 5);

    // Pause request mid-frame
    game_pause = 1'b1;
    ticks(3);
    chk("pend_pause", {31'd0, dip_pause}, 32'd1);
    vb();
    chk("paused", {31'd0, dip_pause}, 32'd0);
    ticks(3);
    chk("paused_hold", {31'd0, dip_pause}, 32'd0);

    // Single-frame step, second step ignored
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_run", {31'd0, dip_pause}, 32'd1);
    ticks(2);
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks(2);
    chk("step_second_ignored", {31'd0, dip_pause}, 32'd1);
    vb();
    chk("step_done", {31'd0, dip_pause}, 32'd0);
    ticks(2);
    chk("step_done_hold", {31'd0, dip_pause}, 32'd0);

    // Release with a simultaneous step: release wins, waits for vblank
    game_pause = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("release_step_same", {31'd0, dip_pause}, 32'd0);
    ticks(3);
    chk("release_wait_vb", {31'd0, dip_pause}, 32'd0);
    vb();
    chk("released", {31'd0, dip_pause}, 32'd1);

    // Reset while in STEP with a pending candidate
    game_pause = 1'b1;
    tick();
    vb();
    chk("pre_rst_paused", {31'd0, dip_pause}, 32'd0);
    status = 32'h5A11_05EE;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("pre_rst_step", {31'd0, dip_pause}, 32'd1);
    ticks(2);
    rst_n = 1'b0;
    game_pause = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    ticks(2);
    rst_n = 1'b1;
    vb();
    tick();
    chk("post_rst_no_commit_cnt",  upd_cnt, 5);
    chk("post_rst_no_commit_bank", {16'd0, dip_bank}, 32'h0);
    chk("post_rst_pause", {31'd0, dip_pause}, 32'd1);
    ticks(10);
    vb();
    tick();
    chk("post_rst_commit_bank", {16'd0, dip_bank}, 32'h5A11);
    chk("post_rst_commit_cnt",  upd_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
